// File: rtl/if_fetch_unit_if.sv
// Port bundle for the instruction-fetch stage: ROM read port, execute redirect
// and the decode valid/ready handshake.
interface if_fetch_unit_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    // Decode handshake: an entry transfers on every rising clk where id_valid_o
    // and id_ready_i are both high. While id_valid_o is high and id_ready_i is
    // low, id_inst_o and id_pc_o do not change.
    logic                  rom_rena_o;
    logic [ADDR_WIDTH-1:0] rom_raddr_o;
    logic [DATA_WIDTH-1:0] rom_rdata_i;
    logic                  jump_en_i;
    logic [ADDR_WIDTH-1:0] jump_addr_i;
    logic                  id_ready_i;
    logic                  id_valid_o;
    logic [DATA_WIDTH-1:0] id_inst_o;
    logic [ADDR_WIDTH-1:0] id_pc_o;

    modport master (
        output rom_rena_o,
        output rom_raddr_o,
        input  rom_rdata_i,
        input  jump_en_i,
        input  jump_addr_i,
        input  id_ready_i,
        output id_valid_o,
        output id_inst_o,
        output id_pc_o
    );

    modport slave (
        input  rom_rena_o,
        input  rom_raddr_o,
        output rom_rdata_i,
        output jump_en_i,
        output jump_addr_i,
        output id_ready_i,
        input  id_valid_o,
        input  id_inst_o,
        input  id_pc_o
    );
endinterface

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, reads a combinational ROM and queues
// {instruction, pc} pairs in a small circular prefetch buffer for decode.
module if_fetch_unit #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
    parameter int                    BUF_DEPTH  = 2
) (
    input logic              clk,
    input logic              arst_n,
    if_fetch_unit_if.master  bus
);
    localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0]      FULL_COUNT = CNT_W'(BUF_DEPTH);
    localparam logic [DATA_WIDTH-1:0] NOP_INST   = DATA_WIDTH'(32'h0000_0013);
    localparam logic [ADDR_WIDTH-1:0] PC_STEP    = ADDR_WIDTH'(4);

    logic [ADDR_WIDTH-1:0] pc;
    logic [DATA_WIDTH-1:0] buf_inst [BUF_DEPTH];
    logic [ADDR_WIDTH-1:0] buf_pc   [BUF_DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      count;

    logic valid;
    logic pop;
    logic fetch;
    logic unused_jump_lsb;

    // Fetching into a full buffer is allowed when the head leaves this cycle.
    assign valid = (count != '0);
    assign pop   = valid & bus.id_ready_i;
    assign fetch = arst_n & ~bus.jump_en_i & ((count < FULL_COUNT) | pop);

    assign unused_jump_lsb = ^bus.jump_addr_i[1:0];

    assign bus.rom_rena_o  = fetch;
    assign bus.rom_raddr_o = pc;
    assign bus.id_valid_o  = valid;
    assign bus.id_inst_o   = valid ? buf_inst[rd_ptr] : NOP_INST;
    assign bus.id_pc_o     = valid ? buf_pc[rd_ptr]   : '0;

    // Control state: reset beats redirect, redirect beats push/pop.
    always_ff @(posedge clk) begin
        if (!arst_n) begin
            pc     <= RESET_PC;
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (bus.jump_en_i) begin
            pc     <= {bus.jump_addr_i[ADDR_WIDTH-1:2], 2'b00};
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (fetch) begin
                pc     <= pc + PC_STEP;
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({fetch, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Payload storage needs no reset: count gates every read.
    always_ff @(posedge clk) begin
        if (fetch) begin
            buf_inst[wr_ptr] <= bus.rom_rdata_i;
            buf_pc[wr_ptr]   <= pc;
        end
    end

    a_no_overflow: assert property (@(posedge clk) count <= FULL_COUNT);

    a_hold_on_stall: assert property (@(posedge clk)
        (arst_n && !bus.jump_en_i && valid && !bus.id_ready_i)
        |=> ($stable(bus.id_pc_o) && $stable(bus.id_inst_o)));

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: directed scenarios plus random
// traffic, compared cycle by cycle against a queue-based fetch model.
module tb_if_fetch_unit;
    localparam int          AW        = 32;
    localparam int          DW        = 32;
    localparam int          DEPTH     = 2;
    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] NOP       = 32'h0000_0013;
    localparam logic [31:0] ROM_KEY   = 32'h5A5A_0000;

    logic clk;
    logic arst_n;

    if_fetch_unit_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    if_fetch_unit #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .RESET_PC  (RESET_PC),
        .BUF_DEPTH (DEPTH)
    ) dut (
        .clk   (clk),
        .arst_n(arst_n),
        .bus   (bus.master)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ROM contents: scrambled so instruction and address are distinguishable.
    function automatic logic [31:0] rom_word(input logic [31:0] a);
        return a ^ ROM_KEY;
    endfunction

    assign bus.rom_rdata_i = rom_word(bus.rom_raddr_o);

    // ---------------- scoreboard / model ----------------
    logic [63:0] exp_q[$];   // {inst, pc} entries waiting for decode
    logic [31:0] model_pc;
    int          checks;
    int          errors;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // One cycle: drive at negedge, check outputs, then advance the model at posedge.
    task automatic step(input logic rst_n_v, input logic jump_v, input logic [31:0] jaddr_v,
                        input logic ready_v);
        logic        exp_valid;
        logic [31:0] exp_inst;
        logic [31:0] exp_pc;
        logic        exp_pop;
        logic        exp_fetch;
        logic [63:0] head;
        @(negedge clk);
        arst_n          = rst_n_v;
        bus.jump_en_i   = jump_v;
        bus.jump_addr_i = jaddr_v;
        bus.id_ready_i  = ready_v;
        #1;
        exp_valid = (exp_q.size() != 0);
        head      = exp_valid ? exp_q[0] : {NOP, 32'h0};
        exp_inst  = head[63:32];
        exp_pc    = head[31:0];
        exp_pop   = exp_valid && ready_v;
        exp_fetch = rst_n_v && !jump_v && ((exp_q.size() < DEPTH) || exp_pop);
        check("id_valid", 32'(bus.id_valid_o), 32'(exp_valid));
        check("id_inst", bus.id_inst_o, exp_inst);
        check("id_pc", bus.id_pc_o, exp_pc);
        check("rom_rena", 32'(bus.rom_rena_o), 32'(exp_fetch));
        check("rom_raddr", bus.rom_raddr_o, model_pc);
        @(posedge clk);
        if (!rst_n_v) begin
            exp_q.delete();
            model_pc = RESET_PC;
        end else if (jump_v) begin
            exp_q.delete();
            model_pc = {jaddr_v[31:2], 2'b00};
        end else begin
            if (exp_pop) void'(exp_q.pop_front());
            if (exp_fetch) begin
                exp_q.push_back({rom_word(model_pc), model_pc});
                model_pc = model_pc + 32'd4;
            end
        end
    endtask

    task automatic run(input int n, input logic ready_v);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 32'h0, ready_v);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic        r_rst;
        logic        r_jump;
        logic [31:0] r_addr;
        checks          = 0;
        errors          = 0;
        arst_n          = 1'b0;
        bus.jump_en_i   = 1'b0;
        bus.jump_addr_i = '0;
        bus.id_ready_i  = 1'b0;
        repeat (2) @(posedge clk);
        exp_q.delete();
        model_pc = RESET_PC;

        // Reset held, then stream with decode always ready.
        step(1'b0, 1'b0, 32'h0, 1'b1);
        step(1'b0, 1'b1, 32'h40, 1'b1);
        run(4, 1'b1);

        // Backpressure fills the buffer, then release.
        run(5, 1'b0);
        run(4, 1'b1);

        // Jump with full buffer and stalled decode.
        run(3, 1'b0);
        step(1'b1, 1'b1, 32'h0000_0103, 1'b0);
        run(5, 1'b1);

        // Jump coincident with a pop.
        step(1'b1, 1'b1, 32'h0000_0200, 1'b1);
        run(3, 1'b1);

        // Back-to-back jumps: the later target wins.
        step(1'b1, 1'b1, 32'h0000_0300, 1'b1);
        step(1'b1, 1'b1, 32'h0000_0402, 1'b1);
        run(3, 1'b1);

        // PC wraps past the top of the address space.
        step(1'b1, 1'b1, 32'hFFFF_FFF8, 1'b1);
        run(6, 1'b1);

        // Reset mid-run with a full buffer.
        run(3, 1'b0);
        step(1'b0, 1'b0, 32'h0, 1'b0);
        run(4, 1'b1);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            r_rst  = ($urandom_range(0, 99) != 0);
            r_jump = ($urandom_range(0, 19) == 0);
            r_addr = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                  : $urandom;
            step(r_rst, r_jump, r_addr, 1'($urandom_range(0, 2) != 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
